// File: rtl/div_pkg.sv
// Shared types and default widths for the sequential restoring divider.
package div_pkg;

  // Controller states: waiting for an operand pair, iterating, holding a result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } div_state_t;

  localparam int DIV_DIVIDEND_W = 16;
  localparam int DIV_DIVISOR_W  = 8;

endpackage : div_pkg

// File: rtl/div_restore_step.sv
// One radix-2 restoring division step: shift the next dividend bit into the
// partial remainder, try subtracting the divisor, keep the difference if it
// did not go negative.
module div_restore_step
  import div_pkg::*;
#(
  parameter int DIVISOR_W = DIV_DIVISOR_W
) (
  input  logic [DIVISOR_W:0]   rem,
  input  logic                 dividend_bit,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_next,
  output logic                 q_bit
);

  localparam int RW = DIVISOR_W + 1;

  // One spare bit above the partial remainder so the shift is lossless even
  // for a remainder that was never reduced below the divisor.
  logic [DIVISOR_W+1:0] shifted;
  logic [DIVISOR_W+1:0] trial;

  assign shifted  = {rem, dividend_bit};
  assign trial    = shifted - {2'b00, divisor};
  assign q_bit    = (shifted >= {2'b00, divisor});
  // The kept value is always < 2*divisor, so it fits the remainder width.
  assign rem_next = RW'(q_bit ? trial : shifted);

endmodule : div_restore_step

// File: rtl/seq_div_uint16_uint8.sv
// Iterative unsigned divider: DIVIDEND_W-bit dividend / DIVISOR_W-bit divisor,
// one quotient bit per cycle, valid/ready handshake on input and output.
module seq_div_uint16_uint8
  import div_pkg::*;
#(
  parameter int DIVIDEND_W = DIV_DIVIDEND_W,
  parameter int DIVISOR_W  = DIV_DIVISOR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DIVIDEND_W-1:0] I0,
  input  logic [DIVISOR_W-1:0]  I1,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DIVIDEND_W-1:0] Q,
  output logic [DIVISOR_W-1:0]  R,
  output logic                  div_zero,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int CNT_W = $clog2(DIVIDEND_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVIDEND_W - 1);

  div_state_t            state_reg, state_next;
  logic                  ready_next;
  logic                  valid_next;

  logic [CNT_W-1:0]      cnt_reg;
  logic [DIVIDEND_W-1:0] dq_reg;       // dividend bits shift out the top, quotient bits in the bottom
  logic [DIVISOR_W-1:0]  divisor_reg;
  logic [DIVISOR_W:0]    rem_reg;

  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVISOR_W-1:0]  r_reg;
  logic                  dz_reg;

  logic [DIVISOR_W:0]    step_rem;
  logic                  step_q;

  div_restore_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .rem          (rem_reg),
    .dividend_bit (dq_reg[DIVIDEND_W-1]),
    .divisor      (divisor_reg),
    .rem_next     (step_rem),
    .q_bit        (step_q)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state_reg;
    ready_next = 1'b0;
    valid_next = 1'b0;
    case (state_reg)
      IDLE: begin
        ready_next = 1'b1;
        if (in_valid) begin
          state_next = (I1 == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
        end
      end
      DONE: begin
        valid_next = 1'b1;
        if (out_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath: operand capture, one restoring step per RUN cycle, result capture.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg     <= '0;
      dq_reg      <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      q_reg       <= '0;
      r_reg       <= '0;
      dz_reg      <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            dq_reg      <= I0;
            divisor_reg <= I1;
            rem_reg     <= '0;
            cnt_reg     <= '0;
            if (I1 == '0) begin
              // Divide by zero skips iteration entirely.
              q_reg  <= '1;
              r_reg  <= I0[DIVISOR_W-1:0];
              dz_reg <= 1'b1;
            end
          end
        end
        RUN: begin
          dq_reg  <= {dq_reg[DIVIDEND_W-2:0], step_q};
          rem_reg <= step_rem;
          if (cnt_reg == CNT_LAST) begin
            q_reg  <= {dq_reg[DIVIDEND_W-2:0], step_q};
            r_reg  <= step_rem[DIVISOR_W-1:0];
            dz_reg <= 1'b0;
          end else begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          // DONE: hold everything so the result stays stable under backpressure.
        end
      endcase
    end
  end

  // Not ready while reset is held, even though the state already reads IDLE.
  assign in_ready  = ready_next & rst_n;
  assign out_valid = valid_next;
  assign Q         = q_reg;
  assign R         = r_reg;
  assign div_zero  = dz_reg;

endmodule : seq_div_uint16_uint8
